// File: rtl/peripheral_timer_pkg.sv
// peripheral_timer_pkg: register map, CONFIG/STATUS bit positions and timer mode encoding.
package peripheral_timer_pkg;
  localparam int REGS_PER_CH = 4;
  localparam int REG_COUNT = 0;
  localparam int REG_RELOAD = 1;
  localparam int REG_CONFIG = 2;
  localparam int REG_STATUS = 3;
  localparam int CFG_EN = 0;
  localparam int CFG_DIR = 1;
  localparam int CFG_MODE_LO = 2;
  localparam int CFG_IRE = 4;
  localparam int CFG_PRE_LO = 8;
  localparam int ST_TC = 0;
  localparam int ST_LT = 1;
  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_FREE_ALT = 2'b11
  } timer_mode_e;
endpackage

// File: rtl/peripheral_timer_array_if.sv
// peripheral_timer_array_if: register bus with per-register write strobes and parallel read-back.
interface peripheral_timer_array_if #(parameter int NREGS = 16);
  logic [NREGS-1:0]       write_en;
  logic [31:0]            data_in;
  logic [NREGS-1:0][31:0] data_out;
  logic                   irq_out;
  modport master(output write_en, data_in, input data_out, irq_out);
  modport slave(input write_en, data_in, output data_out, irq_out);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one counter channel; PERIPHERAL_TIMER_PRESCALE_EN adds a per-channel tick prescaler.
module timer_channel
  import peripheral_timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REGS_PER_CH-1:0]           we_i,
  input  logic [31:0]                      data_i,
  output logic [REGS_PER_CH-1:0][31:0]     rd_o,
  output logic                             irq_o
);
  logic [COUNT_WIDTH-1:0] count_q, count_d, reload_q, reload_d, step;
  logic en_q, en_d, dir_q, dir_d, ire_q, ire_d, tc_q, tc_d, lt_q, lt_d;
  timer_mode_e mode_q, mode_d;
  logic wc, wr, wcfg, ws, tick, term, bounded, adv;
  logic [7:0] pre_rd;
  logic unused_data;
  assign unused_data = ^data_i;
  assign wc = we_i[REG_COUNT];
  assign wr = we_i[REG_RELOAD];
  assign wcfg = we_i[REG_CONFIG];
  assign ws = we_i[REG_STATUS];
`ifdef PERIPHERAL_TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d, psc_q, psc_d;
  assign tick = psc_q == pre_q;
  assign pre_rd = pre_q;
  always_comb begin
    pre_d = wcfg ? data_i[CFG_PRE_LO +: 8] : pre_q;
    psc_d = (wc | wcfg | ~en_q | tick) ? 8'd0 : psc_q + 8'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_q <= '0;
      psc_q <= '0;
    end else begin
      pre_q <= pre_d;
      psc_q <= psc_d;
    end
`else
  assign tick = 1'b1;
  assign pre_rd = 8'd0;
`endif
  assign bounded = (mode_q == MODE_PERIODIC) || (mode_q == MODE_ONESHOT);
  assign term = dir_q ? (bounded ? count_q == reload_q : &count_q) : count_q == '0;
  assign adv = en_q & tick & ~wc;
  assign step = dir_q ? count_q + COUNT_WIDTH'(1) : count_q - COUNT_WIDTH'(1);
  // Terminal handling: periodic reloads, one-shot parks and disables, free-run just wraps.
  always_comb begin
    count_d = wc ? data_i[COUNT_WIDTH-1:0] : !adv ? count_q : !term ? step :
              mode_q == MODE_PERIODIC ? (dir_q ? '0 : reload_q) :
              mode_q == MODE_ONESHOT ? count_q : step;
    reload_d = wr ? data_i[COUNT_WIDTH-1:0] : reload_q;
    en_d = wcfg ? data_i[CFG_EN] : en_q & ~(adv & term & (mode_q == MODE_ONESHOT));
    dir_d = wcfg ? data_i[CFG_DIR] : dir_q;
    mode_d = wcfg ? timer_mode_e'(data_i[CFG_MODE_LO +: 2]) : mode_q;
    ire_d = wcfg ? data_i[CFG_IRE] : ire_q;
    tc_d = (adv & term) | (tc_q & ~(ws & data_i[ST_TC]));
    lt_d = count_d < reload_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      reload_q <= '0;
      en_q <= 1'b0;
      dir_q <= 1'b0;
      mode_q <= MODE_FREE;
      ire_q <= 1'b0;
      tc_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      count_q <= count_d;
      reload_q <= reload_d;
      en_q <= en_d;
      dir_q <= dir_d;
      mode_q <= mode_d;
      ire_q <= ire_d;
      tc_q <= tc_d;
      lt_q <= lt_d;
    end
  assign rd_o[REG_COUNT] = 32'(count_q);
  assign rd_o[REG_RELOAD] = 32'(reload_q);
  assign rd_o[REG_CONFIG] = {16'd0, pre_rd, 3'd0, ire_q, mode_q, dir_q, en_q};
  assign rd_o[REG_STATUS] = {30'd0, lt_q, tc_q};
  assign irq_o = tc_q & ire_q;
endmodule

// File: rtl/peripheral_timer_array.sv
// peripheral_timer_array: multi-channel counter/timer with a registered global interrupt.
module peripheral_timer_array
  import peripheral_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int COUNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  peripheral_timer_array_if.slave bus
);
  logic [CHANNELS-1:0] irq_req;
  logic irq_q, irq_d;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [REGS_PER_CH-1:0][31:0] rd;
    timer_channel #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
      .clk(clk),
      .rst(reset),
      .we_i(bus.write_en[c*REGS_PER_CH +: REGS_PER_CH]),
      .data_i(bus.data_in),
      .rd_o(rd),
      .irq_o(irq_req[c])
    );
    assign bus.data_out[c*REGS_PER_CH +: REGS_PER_CH] = rd;
  end
  assign irq_d = |irq_req;
  always_ff @(posedge clk or posedge reset)
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  assign bus.irq_out = irq_q;
endmodule

// File: tb/tb_peripheral_timer_array.sv
// tb_peripheral_timer_array: randomized + directed stimulus against a behavioural model, scoreboard-checked.
module tb_peripheral_timer_array;
  localparam int CH = 4;
  localparam int W = 8;
  localparam int NR = 4 * CH;
  localparam int MAXV = (1 << W) - 1;
  typedef struct packed {
    logic [NR-1:0][31:0] r;
    logic irq;
  } snap_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  snap_t sb[$];
  int cnt[CH], rel[CH], en[CH], dir[CH], mode[CH], ire[CH], tc[CH], pre[CH], ph[CH];
  peripheral_timer_array_if #(.NREGS(NR)) bus ();
  peripheral_timer_array #(.CHANNELS(CH), .COUNT_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic snap_t mk(input logic irq);
    snap_t s;
    for (int c = 0; c < CH; c++) begin
      s.r[c*4+0] = 32'(cnt[c]);
      s.r[c*4+1] = 32'(rel[c]);
      s.r[c*4+2] = 32'((pre[c] << 8) | (ire[c] << 4) | (mode[c] << 2) | (dir[c] << 1) | en[c]);
      s.r[c*4+3] = 32'(((cnt[c] < rel[c]) ? 2 : 0) | tc[c]);
    end
    s.irq = irq;
    return s;
  endfunction
  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0; rel[c] = 0; en[c] = 0; dir[c] = 0; mode[c] = 0;
      ire[c] = 0; tc[c] = 0; pre[c] = 0; ph[c] = 0;
    end
  endtask
  task automatic model_step(input logic [NR-1:0] we, input logic [31:0] d);
    logic irq_n;
    irq_n = 1'b0;
    for (int c = 0; c < CH; c++) if (tc[c] != 0 && ire[c] != 0) irq_n = 1'b1;
    for (int c = 0; c < CH; c++) begin
      bit wc, wr, wcfg, ws, tick, term, setv;
      int top, nc, nen;
      wc = we[c*4]; wr = we[c*4+1]; wcfg = we[c*4+2]; ws = we[c*4+3];
      tick = en[c] != 0 && ph[c] == pre[c];
      top = (mode[c] == 1 || mode[c] == 2) ? rel[c] : MAXV;
      term = dir[c] != 0 ? cnt[c] == top : cnt[c] == 0;
      nc = cnt[c];
      nen = en[c];
      setv = tick && !wc && term;
      if (tick && !wc) begin
        if (term && mode[c] == 1) nc = dir[c] != 0 ? 0 : rel[c];
        else if (term && mode[c] == 2) nen = 0;
        else nc = (cnt[c] + (dir[c] != 0 ? 1 : -1)) & MAXV;
      end
      if (wc) nc = d & MAXV;
      if (setv) tc[c] = 1;
      else if (ws && d[0]) tc[c] = 0;
      ph[c] = (wc || wcfg || en[c] == 0 || tick) ? 0 : ph[c] + 1;
      cnt[c] = nc;
      en[c] = nen;
      if (wcfg) begin
        en[c] = d[0]; dir[c] = d[1]; mode[c] = (d >> 2) & 3; ire[c] = d[4];
`ifdef PERIPHERAL_TIMER_PRESCALE_EN
        pre[c] = (d >> 8) & 255;
`endif
      end
      if (wr) rel[c] = d & MAXV;
    end
    sb.push_back(mk(irq_n));
  endtask
  task automatic cycle(input logic [NR-1:0] we, input logic [31:0] d);
    @(negedge clk);
    reset = 1'b0;
    bus.write_en = we;
    bus.data_in = d;
    model_step(we, d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.write_en = '0;
    #1;
    tests++;
    if (bus.data_out !== '0 || bus.irq_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: regs_nonzero=%0b irq=%b, required all zero", bus.data_out != '0, bus.irq_out);
    end
    model_clear();
    sb.push_back(mk(1'b0));
  endtask
  task automatic wait_ch1_terminal(input string name);
    for (int i = 0; i < 20 && cnt[1] != 0; i++) cycle('0, 32'd0);
    tests++;
    if (cnt[1] != 0) begin
      fails++;
      $display("FAIL %s: model count %0d never reached terminal 0 within bound", name, cnt[1]);
    end
  endtask
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.data_out !== e.r || bus.irq_out !== e.irq) begin
          int bad;
          bad = -1;
          fails++;
          for (int i = NR - 1; i >= 0; i--) if (bus.data_out[i] !== e.r[i]) bad = i;
          if (bad < 0) $display("FAIL irq_out at %0t: got %b exp %b", $time, bus.irq_out, e.irq);
          else $display("FAIL reg ch%0d off%0d at %0t: got %h exp %h", bad / 4, bad % 4, $time, bus.data_out[bad], e.r[bad]);
        end
      end
    end
  end
  initial begin
    bus.write_en = '0;
    bus.data_in = '0;
    model_clear();
    do_reset();
    cycle(16'h0001, 32'd50);
    cycle(16'h0004, 32'h01);
    idle(10);
    do_reset();
    cycle(16'h0020, 32'd3);
    cycle(16'h0010, 32'd3);
    cycle(16'h0040, 32'h15);
    idle(12);
    cycle(16'h0200, 32'd5);
    cycle(16'h0100, 32'd0);
    cycle(16'h0400, 32'h0B);
    idle(10);
    cycle(16'h1000, 32'hFE);
    cycle(16'h4000, 32'h03);
    idle(4);
    wait_ch1_terminal("w1c_collision_wait");
    cycle(16'h0080, 32'd1);
    cycle(16'h0080, 32'd1);
    wait_ch1_terminal("count_collision_wait");
    cycle(16'h0010, 32'd7);
    idle(3);
    cycle(16'h0054, 32'h15);
    idle(6);
`ifdef PERIPHERAL_TIMER_PRESCALE_EN
    cycle(16'h0001, 32'd4);
    cycle(16'h0004, 32'h0201);
    idle(14);
    cycle(16'h0001, 32'd4);
    cycle(16'h0004, 32'h0001);
    idle(5);
`endif
    for (int n = 0; n < 2500; n++) begin
      logic [NR-1:0] we;
      logic [31:0] d;
      we = '0;
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < NR; i++) we[i] = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom_range(0, 8);
        2: d = ($urandom & 32'h031F) | 32'h1;
        default: d = 32'(MAXV - $urandom_range(0, 8));
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(we, d);
    end
    idle(2);
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
